// File: rtl/block_ram_pkg.sv
// Shared defaults and sizing helper for the single-port block RAM.
package block_ram_pkg;

   localparam int BRAM_WIDTH_DEF      = 8;
   localparam int BRAM_DEPTH_DEF      = 8;
   localparam int BRAM_ADDR_WIDTH_DEF = 32;

   // Index width for a DEPTH-entry array; never narrower than one bit.
   function automatic int bram_idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/block_ram_sp.sv
// Single-port synchronous RAM: write commits on the clock edge; registered read-first output.
// Optional BLOCK_RAM_OOB_FLAG_EN adds a registered out-of-range flag (oob_err).
module block_ram_sp
   import block_ram_pkg::*;
#(
   parameter int WIDTH      = BRAM_WIDTH_DEF,
   parameter int DEPTH      = BRAM_DEPTH_DEF,
   parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [WIDTH-1:0]      data_in,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [WIDTH-1:0]      data_out
`ifdef BLOCK_RAM_OOB_FLAG_EN
   ,
   output logic                  oob_err
`endif
);

   localparam int IDX_W = bram_idx_width(DEPTH);
   localparam int CMP_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
   localparam logic [CMP_W-1:0] DEPTH_CMP = CMP_W'(DEPTH);

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   logic [CMP_W-1:0] addr_cmp;
   logic [IDX_W-1:0] idx;
   logic             in_range;

   // Full-width compare so high address bits never alias into the array.
   assign addr_cmp = CMP_W'(addr);
   assign in_range = (addr_cmp < DEPTH_CMP);
   assign idx      = IDX_W'(addr);

   // reset_n is active-high: writes only happen while it is low.
   always_ff @(posedge clk) begin
      if (!reset_n && wr_en && in_range) begin
         mem[idx] <= data_in;
      end
   end

   // Read register samples mem before the same-edge write lands (read-first).
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         data_out <= '0;
      end else if (in_range) begin
         data_out <= mem[idx];
      end else begin
         data_out <= '0;
      end
   end

`ifdef BLOCK_RAM_OOB_FLAG_EN
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         oob_err <= 1'b0;
      end else begin
         oob_err <= ~in_range;
      end
   end
`endif

endmodule

// File: tb/tb_block_ram_sp.sv
// Bench for block_ram_sp: directed test-plan steps, then random traffic against an array model.
module tb_block_ram_sp;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  data_in;
   logic        wr_en;
   logic [31:0] addr;
   logic [7:0]  data_out;
`ifdef BLOCK_RAM_OOB_FLAG_EN
   logic        oob_err;
`endif

   int vectors = 0;
   int errs    = 0;

   logic [7:0] model [8];
   logic [7:0] exp_out;
   logic       exp_oob;

   block_ram_sp #(.WIDTH(8), .DEPTH(8), .ADDR_WIDTH(32)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .data_in  (data_in),
      .wr_en    (wr_en),
      .addr     (addr),
      .data_out (data_out)
`ifdef BLOCK_RAM_OOB_FLAG_EN
      ,
      .oob_err  (oob_err)
`endif
   );

   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_mem(input string tag);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s mem[%0d]", tag, i), {24'h0, dut.mem[i]}, {24'h0, model[i]});
      end
   endtask

   // One clock of normal operation: drive at negedge, predict at posedge, check just after.
   task automatic step(input string tag, input logic we, input logic [31:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_en = we; addr = a; data_in = d;
      if (a < 8) chk({tag, " mem_pre"}, {24'h0, dut.mem[a[2:0]]}, {24'h0, model[a[2:0]]});
      @(posedge clk);
      exp_out = (a < 8) ? model[a[2:0]] : 8'h00;
      exp_oob = (a >= 8);
      if (we && a < 8) model[a[2:0]] = d;
      #1;
      chk({tag, " data_out"}, {24'h0, data_out}, {24'h0, exp_out});
`ifdef BLOCK_RAM_OOB_FLAG_EN
      chk({tag, " oob_err"}, {31'h0, oob_err}, {31'h0, exp_oob});
`endif
      chk_mem(tag);
   endtask

   initial begin
      reset_n = 1'b1;
      wr_en   = 1'b0;
      addr    = '0;
      data_in = '0;
      for (int i = 0; i < 8; i++) begin
         dut.mem[i] = 8'hFF;
         model[i]   = 8'hFF;
      end

      // Reset state: output held at zero, write attempt ignored.
      @(negedge clk);
      wr_en = 1'b1; addr = 32'd4; data_in = 8'h44;
      @(posedge clk); #1;
      chk("reset data_out", {24'h0, data_out}, 32'h0);
`ifdef BLOCK_RAM_OOB_FLAG_EN
      chk("reset oob_err", {31'h0, oob_err}, 32'h0);
`endif
      chk_mem("reset");
      @(negedge clk);
      wr_en = 1'b0;
      reset_n = 1'b0;

      // Directed test plan
      step("wr0",       1'b1, 32'd0, 8'h00);
      step("rd0",       1'b0, 32'd0, 8'h00);
      step("wr1_off",   1'b0, 32'd1, 8'h01);
      step("wr1_on",    1'b1, 32'd1, 8'h01);
      step("wr2",       1'b1, 32'd2, 8'h02);
      step("rb0",       1'b0, 32'd0, 8'h00);
      step("rb1",       1'b0, 32'd1, 8'h00);
      step("rb2",       1'b0, 32'd2, 8'h00);
      step("rdw3",      1'b1, 32'd3, 8'h5A);
      step("rd3",       1'b0, 32'd3, 8'h00);
      step("oob8",      1'b1, 32'd8, 8'h77);
      step("oob_hi",    1'b1, 32'h8000_0001, 8'h66);
      step("rd1_alias", 1'b0, 32'd1, 8'h00);
      step("rd2_pre",   1'b0, 32'd2, 8'h00);

      // Async reset mid-cycle while data_out holds 0x02
      chk("pre_reset data_out", {24'h0, data_out}, 32'h02);
      #20;
      reset_n = 1'b1;
      #1;
      chk("async reset data_out", {24'h0, data_out}, 32'h0);
      @(negedge clk);
      wr_en = 1'b1; addr = 32'd2; data_in = 8'hAA;
      @(posedge clk); #1;
      chk("reset_wr data_out", {24'h0, data_out}, 32'h0);
      chk_mem("reset_wr");
      @(negedge clk);
      reset_n = 1'b0;
      wr_en = 1'b0;
      step("post_reset_rd2", 1'b0, 32'd2, 8'h00);

      // Random traffic, mostly in range with some out-of-range and wide addresses
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ra;
         ra = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 11));
         step("rand", 1'($urandom_range(0, 1)), ra, 8'($urandom()));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
